// File: rtl/sipo_deser4_pkg.sv
// sipo_deser4_pkg: shared FSM encoding and width limits for the serial deserialiser
package sipo_deser4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;

    function automatic bit width_ok(input int w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// sipo_shift_reg: serial-in shift register; MSB_FIRST only picks the shift direction
module sipo_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_first,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] seeded;

    // Next value when shifting in one more bit, and when starting a fresh frame
    always_comb begin
        shifted = MSB_FIRST ? {q[WIDTH-2:0], din} : {din, q[WIDTH-1:1]};
        seeded  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, din} : {din, {(WIDTH-1){1'b0}}};
    end

    // A frame start wipes any partial word before inserting its first bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (load_first)
            q <= seeded;
        else if (shift_en)
            q <= shifted;
    end

endmodule

// File: rtl/sipo_deser4.sv
// sipo_deser4: framed serial-to-parallel receiver with a single-entry valid/ready output
module sipo_deser4
    import sipo_deser4_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic             s_bit,
    input  logic             s_first,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int CW = $clog2(WIDTH + 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("sipo_deser4: WIDTH must be within 2..16");
    end

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] word;
    logic             start;
    logic             shift;
    logic             done;
    logic             accept;
    logic             pop;

    sipo_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shift (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_first (start),
        .shift_en   (shift),
        .din        (s_bit),
        .q          (q)
    );

    // The word completed this cycle is the shift register's next value, so it can be captured on the same edge
    always_comb begin
        start  = s_valid & s_first;
        shift  = s_valid & ~s_first & (state == ST_SHIFT);
        done   = shift & (count == CW'(WIDTH - 1));
        pop    = p_valid & p_ready;
        accept = ~p_valid | p_ready;
        word   = MSB_FIRST ? {q[WIDTH-2:0], s_bit} : {s_bit, q[WIDTH-1:1]};
        busy   = (state == ST_SHIFT);
    end

    // Frame FSM, bit counter, holding register and sticky flags; a flag being set beats clr_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            count     <= '0;
            p_data    <= '0;
            p_valid   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (start) begin
                state <= ST_SHIFT;
                count <= CW'(1);
            end else if (shift) begin
                state <= done ? ST_IDLE : ST_SHIFT;
                count <= done ? '0 : count + 1'b1;
            end
            if (done && accept) begin
                p_data  <= word;
                p_valid <= 1'b1;
            end else if (pop) begin
                p_valid <= 1'b0;
            end
            overrun   <= (done & ~accept) | (overrun & ~clr_err);
            frame_err <= (start & (state == ST_SHIFT)) | (frame_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_sipo_deser4.sv
// tb_sipo_deser4: directed checks of framing, handoff, sticky flags and reset for both bit orders
module tb_sipo_deser4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_bit = 1'b0;
    logic       s_first = 1'b0;
    logic       p_ready = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] m_data, l_data;
    logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr, m_ferr, l_ferr;

    int total = 0;
    int bad = 0;
    int pops = 0;

    sipo_deser4 #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_first(s_first),
        .p_data(m_data), .p_valid(m_valid), .p_ready(p_ready), .busy(m_busy),
        .overrun(m_ovr), .frame_err(m_ferr), .clr_err(clr_err)
    );

    sipo_deser4 #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_bit(s_bit), .s_first(s_first),
        .p_data(l_data), .p_valid(l_valid), .p_ready(p_ready), .busy(l_busy),
        .overrun(l_ovr), .frame_err(l_ferr), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Count words actually handed to the consumer by the MSB-first instance
    always @(posedge clk) begin
        if (rst_n && m_valid && p_ready)
            pops <= pops + 1;
    end

    // One serial bit: driven at a falling edge, sampled by the next rising edge, returns at the following falling edge
    task automatic send_bit(input logic b, input logic f);
        s_valid = 1'b1;
        s_bit   = b;
        s_first = f;
        @(negedge clk);
        s_valid = 1'b0;
        s_first = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--)
            send_bit(w[i], i == 3);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        total += 10;
        if (m_data !== 4'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        if (m_busy !== 1'b0) begin bad++; $display("FAIL reset_m_busy got=%b want=0", m_busy); end
        if (m_ovr !== 1'b0) begin bad++; $display("FAIL reset_m_ovr got=%b want=0", m_ovr); end
        if (m_ferr !== 1'b0) begin bad++; $display("FAIL reset_m_ferr got=%b want=0", m_ferr); end
        if (l_data !== 4'h0) begin bad++; $display("FAIL reset_l_data got=%h want=0", l_data); end
        if (l_valid !== 1'b0) begin bad++; $display("FAIL reset_l_valid got=%b want=0", l_valid); end
        if (l_busy !== 1'b0) begin bad++; $display("FAIL reset_l_busy got=%b want=0", l_busy); end
        if (l_ovr !== 1'b0) begin bad++; $display("FAIL reset_l_ovr got=%b want=0", l_ovr); end
        if (l_ferr !== 1'b0) begin bad++; $display("FAIL reset_l_ferr got=%b want=0", l_ferr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bit_order;
        p_ready = 1'b1;
        send_bit(1'b1, 1'b1);
        total++;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL order_busy got=%b want=1", m_busy); end
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        total += 5;
        if (m_data !== 4'b1011) begin bad++; $display("FAIL order_msb_data got=%b want=1011", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL order_msb_valid got=%b want=1", m_valid); end
        if (l_data !== 4'b1101) begin bad++; $display("FAIL order_lsb_data got=%b want=1101", l_data); end
        if (l_valid !== 1'b1) begin bad++; $display("FAIL order_lsb_valid got=%b want=1", l_valid); end
        if (m_busy !== 1'b0) begin bad++; $display("FAIL order_idle got=%b want=0", m_busy); end
        @(negedge clk);
        total += 2;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL order_popped got=%b want=0", m_valid); end
        if (m_data !== 4'b1011) begin bad++; $display("FAIL order_hold_data got=%b want=1011", m_data); end
        p_ready = 1'b0;
    endtask

    task automatic test_overrun;
        p_ready = 1'b0;
        send_word(4'hA);
        send_word(4'h3);
        @(negedge clk);
        total += 4;
        if (m_data !== 4'hA) begin bad++; $display("FAIL ovr_data got=%h want=a", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", m_valid); end
        if (m_ovr !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", m_ovr); end
        if (l_data !== 4'h5) begin bad++; $display("FAIL ovr_lsb_data got=%h want=5", l_data); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total += 3;
        if (m_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b want=0", m_ovr); end
        if (m_data !== 4'hA) begin bad++; $display("FAIL ovr_keep got=%h want=a", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL ovr_keep_valid got=%b want=1", m_valid); end
        p_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL ovr_drain got=%b want=0", m_valid); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] c;
        c = 4'hC;
        send_word(4'h5);
        for (int i = 3; i >= 1; i--) begin
            send_bit(c[i], i == 3);
            total += 2;
            if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_pending_valid bit=%0d got=%b want=1", i, m_valid); end
            if (m_data !== 4'h5) begin bad++; $display("FAIL b2b_pending_data bit=%0d got=%h want=5", i, m_data); end
        end
        p_ready = 1'b1;
        send_bit(c[0], 1'b0);
        p_ready = 1'b0;
        total += 3;
        if (m_data !== 4'hC) begin bad++; $display("FAIL b2b_data got=%h want=c", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", m_valid); end
        if (m_ovr !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%b want=0", m_ovr); end
        p_ready = 1'b1;
        @(negedge clk);
        p_ready = 1'b0;
    endtask

    task automatic test_frame_err;
        int base;
        p_ready = 1'b1;
        base = pops;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        total++;
        if (m_ferr !== 1'b0) begin bad++; $display("FAIL ferr_early got=%b want=0", m_ferr); end
        clr_err = 1'b1;
        send_bit(1'b0, 1'b1);
        clr_err = 1'b0;
        total++;
        if (m_ferr !== 1'b1) begin bad++; $display("FAIL ferr_set_wins got=%b want=1", m_ferr); end
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        total += 3;
        if (m_data !== 4'b0110) begin bad++; $display("FAIL ferr_data got=%b want=0110", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL ferr_valid got=%b want=1", m_valid); end
        if (m_ferr !== 1'b1) begin bad++; $display("FAIL ferr_sticky got=%b want=1", m_ferr); end
        @(negedge clk);
        @(negedge clk);
        total += 2;
        if (pops - base !== 1) begin bad++; $display("FAIL ferr_words got=%0d want=1", pops - base); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL ferr_drained got=%b want=0", m_valid); end
        p_ready = 1'b0;
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++;
        if (m_ferr !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b want=0", m_ferr); end
    endtask

    task automatic test_reset_mid;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        total++;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", m_busy); end
        rst_n = 1'b0;
        #1;
        total += 4;
        if (m_data !== 4'h0) begin bad++; $display("FAIL mid_data got=%h want=0", m_data); end
        if (m_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_rst got=%b want=0", m_busy); end
        if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", m_valid); end
        if (m_ferr !== 1'b0) begin bad++; $display("FAIL mid_ferr got=%b want=0", m_ferr); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_word(4'b1001);
        total += 4;
        if (m_data !== 4'b1001) begin bad++; $display("FAIL mid_after_data got=%b want=1001", m_data); end
        if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_after_valid got=%b want=1", m_valid); end
        if (l_data !== 4'b1001) begin bad++; $display("FAIL mid_after_lsb got=%b want=1001", l_data); end
        if (m_ferr !== 1'b0) begin bad++; $display("FAIL mid_after_ferr got=%b want=0", m_ferr); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_bit_order;
        test_overrun;
        test_back_to_back;
        test_frame_err;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
